// File: rtl/dmem_bridge.sv
// dmem_bridge: LSU to data-memory bus bridge.
//
// Turns the LSU's level-held read/write request into exactly one
// req/gnt/rvalid bus transaction. The completion strobe and err_o are held
// while the pipeline is stalled, so a stalled load/store is never reissued.
//
// Optional feature (macro DMEM_TIMEOUT_EN): aborts a transaction that spends
// TIMEOUT_CYCLES in REQ plus WAIT_RESP. The access then completes with
// err_o = 1 and lsu_rdata_o unchanged. When the macro is undefined the bridge
// waits indefinitely.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   lsu_memr_i/memw_i    LSU read/write request, held until completion
//   lsu_addr_i/wdata_i   LSU address and lane-replicated store data
//   lsu_be_i             LSU byte enables
//   stall_i              pipeline stall; holds the completed result
//   lsu_rdata_o          last completed load word
//   lsu_read_valid_o     load complete (held through stall)
//   lsu_write_ready_o    store complete (held through stall)
//   err_o                bus error or timeout for the completed access
//   busy_o               transaction in flight
//   data_*               registered bus request side plus response inputs
module dmem_bridge
`ifdef DMEM_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 255
  )
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_memr_i,
  input  logic        lsu_memw_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_be_i,
  input  logic        stall_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_read_valid_o,
  output logic        lsu_write_ready_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp, StDone} state_e;

  state_e      state_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_q;
  logic [31:0] rdata_q;
  logic        read_valid_q;
  logic        write_ready_q;
  logic        err_q;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            tmo_hit;

  // Counter value k means k+1 cycles have been spent in REQ/WAIT_RESP.
  assign tmo_hit = (tmo_cnt_q == TmoLast);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      req_q         <= 1'b0;
      rdata_q       <= '0;
      read_valid_q  <= 1'b0;
      write_ready_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lsu_memr_i || lsu_memw_i) begin
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_wdata_i;
            be_q    <= lsu_be_i;
            // Read wins when both requests are raised together.
            we_q    <= lsu_memw_i & ~lsu_memr_i;
            req_q   <= 1'b1;
            state_q <= StReq;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        StReq: begin
`ifdef DMEM_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + CntW'(1);
`endif
          // rvalid is not legal before the cycle after grant, so it is ignored here.
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= StWaitResp;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_hit) begin
            req_q         <= 1'b0;
            err_q         <= 1'b1;
            read_valid_q  <= ~we_q;
            write_ready_q <= we_q;
            state_q       <= StDone;
          end
`endif
        end
        StWaitResp: begin
`ifdef DMEM_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + CntW'(1);
`endif
          if (data_rvalid_i) begin
            err_q         <= data_err_i;
            read_valid_q  <= ~we_q;
            write_ready_q <= we_q;
            if (!we_q) begin
              rdata_q <= data_rdata_i;
            end
            state_q <= StDone;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q         <= 1'b1;
            read_valid_q  <= ~we_q;
            write_ready_q <= we_q;
            state_q       <= StDone;
          end
`endif
        end
        StDone: begin
          // Stay here while stalled so the still-high LSU request is not reissued.
          if (!stall_i) begin
            read_valid_q  <= 1'b0;
            write_ready_q <= 1'b0;
            err_q         <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_rdata_o       = rdata_q;
  assign lsu_read_valid_o  = read_valid_q;
  assign lsu_write_ready_o = write_ready_q;
  assign err_o             = err_q;
  assign busy_o            = (state_q != StIdle);
  assign data_req_o        = req_q;
  assign data_we_o         = we_q;
  assign data_addr_o       = addr_q;
  assign data_be_o         = be_q;
  assign data_wdata_o      = wdata_q;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the load/store unit and the data-memory bus.
- Converts the LSU's level-held read/write request into one request/grant/response bus transaction.
- Returns load data and completion strobes to the LSU.
- Holds the completed result while the pipeline is stalled, so a stalled load/store never issues a second bus access.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT_RESP before abort. Used only with DMEM_TIMEOUT_EN. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- lsu_memr_i  in  1  LSU read request, held high until completion.
- lsu_memw_i  in  1  LSU write request, held high until completion.
- lsu_addr_i  in  32  word-aligned address from LSU.
- lsu_wdata_i  in  32  lane-replicated store data.
- lsu_be_i  in  4  byte enables.
- stall_i  in  1  pipeline stall; the current memory instruction does not retire this cycle.
- lsu_rdata_o  out  32  raw load word to LSU.
- lsu_read_valid_o  out  1  load complete, data valid.
- lsu_write_ready_o  out  1  store complete.
- err_o  out  1  bus error (or timeout) for the completed access.
- busy_o  out  1  transaction in flight (state != IDLE).
- data_req_o  out  1  bus request.
- data_we_o  out  1  1 = write.
- data_addr_o  out  32  bus address.
- data_be_o  out  4  bus byte enables.
- data_wdata_o  out  32  bus write data.
- data_gnt_i  in  1  bus grant.
- data_rvalid_i  in  1  response valid (reads and writes).
- data_rdata_i  in  32  response read data.
- data_err_i  in  1  response error, qualified by data_rvalid_i.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All outputs 0; lsu_rdata_o = 0.
  - Latched address, data, byte enables and we cleared.
  - Any in-flight bus transaction is abandoned; the bus agent is reset by the same signal.
- All bus outputs are registered and held stable from request assertion until grant.
- States: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - On lsu_memr_i or lsu_memw_i, latch addr, wdata, be and we (we = lsu_memw_i & ~lsu_memr_i; read wins if both are high), then go to REQ.
  - data_req_o rises the cycle after the LSU request is first seen.
- REQ:
  - data_req_o = 1.
  - On data_gnt_i, go to WAIT_RESP; data_req_o falls the next cycle.
  - data_rvalid_i is ignored in REQ; the earliest legal response is the cycle after grant.
  - LSU input changes in REQ are ignored.
- WAIT_RESP:
  - On data_rvalid_i, err_o <= data_err_i.
  - If read, lsu_rdata_o <= data_rdata_i. Writes leave lsu_rdata_o unchanged.
  - Go to DONE.
- DONE:
  - lsu_read_valid_o (read) or lsu_write_ready_o (write) = 1 for every DONE cycle; err_o is held.
  - Minimum one cycle in DONE.
  - Exit to IDLE in a cycle where stall_i = 0; the strobes and err_o clear on exit.
  - While stall_i = 1, remain in DONE and issue no new bus request, even though lsu_mem*_i stay high.
- lsu_rdata_o holds the last completed read value until the next read completes.
- Latency, zero-wait bus (grant same cycle as request, response the next cycle): LSU request at cycle 0 gives data_req_o at 1, grant at 1, rvalid at 2, read_valid at 3.
- Back-to-back accesses: DONE -> IDLE -> REQ, so one idle cycle occurs between transactions.
- Errors:
  - An error response still completes the access (strobe asserted) with err_o = 1.
  - Recovery is handled by the core.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_RESP.
  - On reaching TIMEOUT_CYCLES without a response, go to DONE with err_o = 1 and the strobe asserted; lsu_rdata_o is unchanged and data_req_o drops.
  - A response arriving later is ignored while not in WAIT_RESP.
- Not defined: no counter; the block waits indefinitely in REQ or WAIT_RESP.

Test Plan:
- Zero-wait read: addr 0x0000_1004, gnt on the first request cycle, rvalid next with rdata 0xDEAD_BEEF -> single req pulse, read_valid at cycle 3, lsu_rdata_o = 0xDEAD_BEEF, err_o = 0.
- Write with 3-cycle grant delay: be 4'b1100, wdata 0xAB12_AB12 -> data_req_o, addr, be and wdata stable for 4 cycles, we = 1, write_ready after rvalid, lsu_rdata_o unchanged.
- Stall after completion: load completes, stall_i held 5 cycles with lsu_memr_i high -> exactly one bus request, read_valid high 5 cycles plus the release cycle, then IDLE.
- Error response: read with rvalid and data_err_i = 1 -> read_valid = 1, err_o = 1; the next clean access shows err_o = 0.
- Reset mid-transaction: rst low during WAIT_RESP -> all outputs 0 immediately (asynchronous); after release, state is IDLE and a new request issues normally.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8: gnt never asserted -> DONE after 8 cycles with err_o = 1, write_ready/read_valid = 1, data_req_o = 0.
